// File: rtl/score_counter.sv
// Three-digit BCD score with a one-digit-per-cycle adder and frame-synchronous display.
// Optional build macro SCORE_WRAP_EN: wrap modulo 1000 instead of saturating at 999.
module score_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc_valid,
  input  logic [3:0] inc_val,
  output logic       inc_ready,
  input  logic       clr,
  input  logic       frame_tick,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig,
  output logic       sat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD0 = 2'd1;
  localparam logic [1:0] ADD1 = 2'd2;
  localparam logic [1:0] ADD2 = 2'd3;

  logic [1:0] state;
  logic [3:0] amt;
  logic [3:0] c0, c1, c2;
  logic [3:0] s0, s1;
  logic       carry;

  logic [3:0] add_a, add_b;
  logic [4:0] add_raw;
  logic [3:0] add_dig;
  logic       add_cy;

  // One shared BCD digit adder; the state selects which committed digit feeds it.
  always_comb begin
    add_a = c0;
    add_b = amt;
    case (state)
      ADD1: begin
        add_a = c1;
        add_b = {3'b000, carry};
      end
      ADD2: begin
        add_a = c2;
        add_b = {3'b000, carry};
      end
      default: ;
    endcase
    add_raw = {1'b0, add_a} + {1'b0, add_b};
    add_cy  = (add_raw > 5'd9);
    add_dig = add_cy ? 4'(add_raw - 5'd10) : add_raw[3:0];
  end

  assign inc_ready = reset_n && (state == IDLE) && !clr;

`ifdef SCORE_WRAP_EN
  assign sat = 1'b0;
`else
  logic sat_q;
  assign sat = sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (clr) begin
      sat_q <= 1'b0;
    end else if (state == ADD2 && add_cy) begin
      sat_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      amt   <= 4'd0;
      c0    <= 4'd0;
      c1    <= 4'd0;
      c2    <= 4'd0;
      s0    <= 4'd0;
      s1    <= 4'd0;
      carry <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      c0    <= 4'd0;
      c1    <= 4'd0;
      c2    <= 4'd0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inc_valid && inc_ready) begin
            amt   <= (inc_val > 4'd9) ? 4'd9 : inc_val;
            state <= ADD0;
          end
        end
        ADD0: begin
          s0    <= add_dig;
          carry <= add_cy;
          state <= ADD1;
        end
        ADD1: begin
          s1    <= add_dig;
          carry <= add_cy;
          state <= ADD2;
        end
        ADD2: begin
          // All three digits land together so the display never sees a half-updated score.
`ifdef SCORE_WRAP_EN
          c0 <= s0;
          c1 <= s1;
          c2 <= add_dig;
`else
          if (!sat_q) begin
            if (add_cy) begin
              c0 <= 4'd9;
              c1 <= 4'd9;
              c2 <= 4'd9;
            end else begin
              c0 <= s0;
              c1 <= s1;
              c2 <= add_dig;
            end
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display latches the pre-edge committed score, so a same-edge commit shows next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig0 <= 5'd0;
      dig1 <= 5'd0;
      dig  <= 5'd0;
    end else if (frame_tick) begin
      dig0 <= {1'b0, c0};
      dig1 <= {1'b0, c1};
      dig  <= {1'b0, c2};
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Directed and randomized checks of score_counter against an integer score model.
module tb_score_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inc_valid;
  logic [3:0] inc_val;
  logic       inc_ready;
  logic       clr;
  logic       frame_tick;
  logic [4:0] dig0, dig1, dig;
  logic       sat;

  score_counter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_valid  (inc_valid),
    .inc_val    (inc_val),
    .inc_ready  (inc_ready),
    .clr        (clr),
    .frame_tick (frame_tick),
    .dig0       (dig0),
    .dig1       (dig1),
    .dig        (dig),
    .sat        (sat)
  );

  always #5 clk = ~clk;

`ifdef SCORE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: committed score as an integer, displayed value, pending add countdown.
  int score = 0;
  int disp  = 0;
  int busy  = 0;
  int pend  = 0;
  bit msat  = 1'b0;
  bit last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    score = 0; disp = 0; busy = 0; pend = 0; msat = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] val, input bit c, input bit t);
    int sum;
    if (t) disp = score;
    if (c) begin
      score = 0; msat = 1'b0; busy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && !msat) begin
        sum = score + pend;
        if (sum > 999) begin
          if (WRAP) score = sum - 1000;
          else begin score = 999; msat = 1'b1; end
        end else score = sum;
      end
    end else if (v) begin
      pend = (val > 9) ? 9 : int'(val);
      busy = 3;
    end
  endtask

  task automatic check_outputs();
    check("dig0", dig0, disp % 10);
    check("dig1", dig1, (disp / 10) % 10);
    check("dig",  dig,  disp / 100);
    check("sat",  sat,  msat);
  endtask

  task automatic cyc(input bit v, input logic [3:0] val, input bit c, input bit t);
    bit rdy;
    @(negedge clk);
    inc_valid = v; inc_val = val; clr = c; frame_tick = t;
    #1;
    rdy = (busy == 0) && !c;
    last_ready = inc_ready;
    check("inc_ready", inc_ready, rdy);
    @(posedge clk);
    model_edge(v, val, c, t);
    #1;
    check_outputs();
  endtask

  task automatic add(input logic [3:0] val);
    cyc(1'b1, val, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic show_expect(input string tag, input int value);
    check({tag, "_d0"}, dig0, value % 10);
    check({tag, "_d1"}, dig1, (value / 10) % 10);
    check({tag, "_d2"}, dig,  value / 100);
  endtask

  initial begin
    int lowcnt;
    reset_n = 1'b0; inc_valid = 1'b0; inc_val = 4'd0; clr = 1'b0; frame_tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_inc_ready", inc_ready, 0);
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Single add of 7: three busy cycles, then a tick shows 007
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    check("first_ready", last_ready, 1);
    lowcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      if (last_ready) break;
      lowcnt++;
    end
    check("busy_cycles", lowcnt, 3);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("add7", 7);

    // 095 + 8: tick on the commit edge still shows 095
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (10) add(4'd9);
    add(4'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("pre95", 95);
    cyc(1'b1, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("commit_edge", 95);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("after103", 103);

    // 995 + 9: saturate (or wrap), then a further add
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (110) add(4'd9);
    add(4'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("pre995", 995);
    add(4'd9);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("limit", WRAP ? 4 : 999);
    check("limit_sat", sat, WRAP ? 0 : 1);
    add(4'd1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("limit_again", WRAP ? 5 : 999);

    // Over-range amount clamps to 9; clr also clears sat
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_sat", sat, 0);
    add(4'd15);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("clamp15", 9);

    // clr during ADD1 of 050+6 aborts the add
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (5) add(4'd9);
    add(4'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("pre50", 50);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    show_expect("held50", 50);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("abort", 0);

    // Async reset pulse during ADD2 discards the pending add
    add(4'd3);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("pre3", 3);
    cyc(1'b1, 4'd4, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    inc_valid = 1'b0; clr = 1'b0; frame_tick = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_inc_ready", inc_ready, 0);
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", inc_ready, 1);
    repeat (4) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    show_expect("no_partial", 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL expose: clk  input  1  system/pixel clock; all state changes on rising edge.
REQ-002 SHALL expose: reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL expose: inc_valid  input  1  add request.
REQ-004 SHALL expose: inc_val  input  4  binary amount to add; values above 9 are treated as 9.
REQ-005 SHALL expose: inc_ready  output  1  high when an add request can be accepted.
REQ-006 SHALL expose: clr  input  1  single-cycle clear request.
REQ-007 SHALL expose: frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-008 SHALL expose: dig0, dig1, dig  output  5 each  displayed ones, tens, hundreds BCD digits; bit 4 always 0, bits 3:0 in range 0-9.
REQ-009 SHALL expose: sat  output  1  sticky flag, score has reached its saturation limit.

Function
REQ-010 SHALL hold a committed 3-digit BCD score (c2,c1,c0), range 000-999.
REQ-011 SHALL run an FSM with states IDLE, ADD0, ADD1, ADD2; inc_ready is high only in IDLE with clr low.
REQ-012 SHALL accept a request on a rising edge where inc_valid and inc_ready are both high, and move to ADD0.
REQ-013 SHALL capture min(inc_val, 9) in a holding register on acceptance.
REQ-014 SHALL make ADD0 add the held amount to c0, ADD1 add the carry to c1, and ADD2 add the carry to c2, using scratch digits.
REQ-015 SHALL perform one BCD digit add per cycle; a digit sum above 9 produces digit-10 and carry 1.
REQ-016 SHALL write all three scratch digits to the committed score in one edge, at the end of ADD2, then return to IDLE.
REQ-017 SHALL give a latency of: accepted at edge E, committed at edge E+3, inc_ready high again in the cycle after E+3.
REQ-018 SHALL, on carry out of the hundreds digit, commit 999 and set sat.
REQ-019 SHALL, when sat=1, accept add requests without changing the score.
REQ-020 SHALL update dig0/dig1/dig only on edges where frame_tick=1, loading the committed score as it stood before that edge.
REQ-021 SHALL, when a commit and frame_tick fall on the same edge, display the pre-commit value; the new value appears at the next frame_tick.
REQ-022 SHALL, on clr=1, zero the committed score, clear sat, abort any ADDx in progress (the aborted add is lost), and enter IDLE.
REQ-023 SHALL give clr priority over inc_valid and over a commit on the same edge.
REQ-024 SHALL leave the displayed digits unchanged after clr until the next frame_tick, which then shows 000.
REQ-025 SHALL keep inc_ready low in the cycle clr is asserted.

Reset
REQ-026 SHALL, while reset_n=0, force: FSM=IDLE, committed score=000, scratch=000, held amount=0, dig0=dig1=dig=5'd0, sat=0.
REQ-027 SHALL assert inc_ready=1 in the first cycle after reset_n deasserts.
REQ-028 SHALL let reset during ADDx discard the pending add with no partial commit.

Configuration
REQ-029 SHALL, when SCORE_WRAP_EN is defined, replace REQ-018/REQ-019 with wrap: carry out of hundreds is dropped (score modulo 1000) and sat is tied to 0.
REQ-030 SHALL, without SCORE_WRAP_EN, apply saturation per REQ-018/REQ-019.

Verification
REQ-031 SHALL cover: reset, then inc_val=7 accepted, then frame_tick after commit -> dig=0, dig1=0, dig0=7; inc_ready low for exactly 3 cycles.
REQ-032 SHALL cover: score 095 plus inc_val=8 -> commit 103 at E+3; a frame_tick at E+3 shows 095, the next frame_tick shows 103.
REQ-033 SHALL cover: score 995 plus inc_val=9 -> default build 999 with sat=1, then a further add leaves 999; SCORE_WRAP_EN build gives 004 with sat=0.
REQ-034 SHALL cover: inc_val=15 -> treated as 9.
REQ-035 SHALL cover: clr asserted in ADD1 of 050+6 -> committed 000, no 056 commit, display keeps 050 until the next frame_tick shows 000.
REQ-036 SHALL cover: reset_n low for one cycle mid-ADD2 -> all outputs 0 immediately (asynchronous), inc_ready=1 after release.
